// File: rtl/reg8_share_arbiter.sv
// rtl/reg8_share_arbiter.sv - round-robin write arbiter owning one shared register with a post-write hold window
// Optional REG8_ARB_OWNER_EN adds owner_o, the index of the requester that last wrote q_o.
module reg8_share_arbiter #(
    parameter int               NUM_REQ     = 4,
    parameter int               WIDTH       = 8,
    parameter int               HOLD_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]         q_o,
    output logic                     q_upd_o,
    output logic                     busy_o
`ifdef REG8_ARB_OWNER_EN
    ,
    output logic [$clog2(NUM_REQ)-1:0] owner_o
`endif
);

    localparam int         IDXW      = $clog2(NUM_REQ);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_HOLD   = 1'b1;
    localparam logic [7:0] HOLD_INIT = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);

    logic [0:0]      state_q, state_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic            q_upd_q, q_upd_d;
    logic            found;
    logic [IDXW-1:0] winner;
    logic            transfer;

    // Scan starts at the pointer and wraps, so the last writer has lowest priority next time.
    always_comb begin : pick
        logic [IDXW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDXW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (!reset_i && state_q == ST_IDLE && found) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    assign transfer = |req_ready_o;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        q_d        = q_q;
        q_upd_d    = transfer;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    q_d   = req_data_i[int'(winner)*WIDTH +: WIDTH];
                    ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
                    if (HOLD_CYCLES != 0) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_INIT;
                    end
                end
            end
            default: begin
                if (hold_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 8'd0;
            ptr_q      <= '0;
            q_q        <= RESET_VALUE;
            q_upd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
            q_q        <= q_d;
            q_upd_q    <= q_upd_d;
        end
    end

    assign q_o     = q_q;
    assign q_upd_o = q_upd_q;
    assign busy_o  = (state_q == ST_HOLD);

`ifdef REG8_ARB_OWNER_EN
    logic [IDXW-1:0] owner_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_q <= '0;
        end else if (transfer) begin
            owner_q <= winner;
        end
    end

    assign owner_o = owner_q;
`endif

endmodule

// File: tb/tb_reg8_share_arbiter.sv
// tb/tb_reg8_share_arbiter.sv - randomized and directed bench for reg8_share_arbiter (HOLD_CYCLES=2 and 0)
module tb_reg8_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   va, vb, ready_a, ready_b;
    logic [N*W-1:0] da, db;
    logic [W-1:0]   q_a, q_b;
    logic           upd_a, upd_b, busy_a, busy_b;
    logic [1:0]     own_a, own_b;

    reg8_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(2), .RESET_VALUE(8'h00)) dut_a (
        .clk_i(clk), .reset_i(rst), .req_valid_i(va), .req_data_i(da),
        .req_ready_o(ready_a), .q_o(q_a), .q_upd_o(upd_a), .busy_o(busy_a)
`ifdef REG8_ARB_OWNER_EN
        , .owner_o(own_a)
`endif
    );

    reg8_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(0), .RESET_VALUE(8'h00)) dut_b (
        .clk_i(clk), .reset_i(rst), .req_valid_i(vb), .req_data_i(db),
        .req_ready_o(ready_b), .q_o(q_b), .q_upd_o(upd_b), .busy_o(busy_b)
`ifdef REG8_ARB_OWNER_EN
        , .owner_o(own_b)
`endif
    );

`ifndef REG8_ARB_OWNER_EN
    assign own_a = 2'd0;
    assign own_b = 2'd0;
`endif

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: index 0 tracks dut_a (hold 2), index 1 tracks dut_b (hold 0).
    int hold_of[2] = '{2, 0};
    int m_q[2], m_ptr[2], m_hold[2], m_upd[2], m_own[2];

    function automatic int pick(input int m, input logic [N-1:0] vv);
        for (int k = 0; k < N; k++) begin
            if (vv[(m_ptr[m] + k) % N]) return (m_ptr[m] + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m, input logic [N-1:0] vv);
        int w;
        w = pick(m, vv);
        if (rst || m_hold[m] > 0 || w < 0) return '0;
        return N'(1) << w;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_q[m] = 0; m_ptr[m] = 0; m_hold[m] = 0; m_upd[m] = 0; m_own[m] = 0;
        end
    endtask

    task automatic model_edge(input int m, input logic [N-1:0] vv, input logic [N*W-1:0] dd);
        int w;
        w = pick(m, vv);
        if (rst) begin
            m_q[m] = 0; m_ptr[m] = 0; m_hold[m] = 0; m_upd[m] = 0; m_own[m] = 0;
        end else if (m_hold[m] > 0) begin
            m_hold[m]--;
            m_upd[m] = 0;
        end else if (w >= 0) begin
            m_q[m]    = int'(dd[w*W +: W]);
            m_upd[m]  = 1;
            m_ptr[m]  = (w + 1) % N;
            m_own[m]  = w;
            m_hold[m] = hold_of[m];
        end else begin
            m_upd[m] = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_eq("ready_a", 32'(ready_a), 32'(exp_ready(0, va)));
        check_eq("q_a",     32'(q_a),     32'(m_q[0]));
        check_eq("upd_a",   32'(upd_a),   32'(m_upd[0]));
        check_eq("busy_a",  32'(busy_a),  32'(m_hold[0] > 0));
        check_eq("ready_b", 32'(ready_b), 32'(exp_ready(1, vb)));
        check_eq("q_b",     32'(q_b),     32'(m_q[1]));
        check_eq("upd_b",   32'(upd_b),   32'(m_upd[1]));
        check_eq("busy_b",  32'(busy_b),  32'(m_hold[1] > 0));
`ifdef REG8_ARB_OWNER_EN
        check_eq("own_a",   32'(own_a),   32'(m_own[0]));
        check_eq("own_b",   32'(own_b),   32'(m_own[1]));
`endif
        @(posedge clk);
        model_edge(0, va, da);
        model_edge(1, vb, db);
        #1;
    endtask

    logic [W-1:0] seen[$];
    logic [W-1:0] t3_exp[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    initial begin
        rst = 1'b1; va = '0; vb = '0; da = '0; db = '0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();

        // Reset held with no requests
        cycle(); cycle();
        rst = 1'b0;
        check_eq("t1_q", 32'(q_a), 32'h00);
        check_eq("t1_busy", 32'(busy_a), 32'h0);
        check_eq("t1_upd", 32'(upd_a), 32'h0);

        // Single write from requester 2
        va = 4'b0100; da = 32'h00A5_0000; #1;
        check_eq("t2_ready", 32'(ready_a), 32'b0100);
        cycle();
        va = '0;
        check_eq("t2_q", 32'(q_a), 32'hA5);
        check_eq("t2_upd", 32'(upd_a), 32'h1);
        check_eq("t2_busy1", 32'(busy_a), 32'h1);
        cycle();
        check_eq("t2_busy2", 32'(busy_a), 32'h1);
        cycle();
        check_eq("t2_idle", 32'(busy_a), 32'h0);

        // All requesters valid: rotation with writes 3 cycles apart
        rst = 1'b1; cycle(); rst = 1'b0;
        va = 4'b1111; da = 32'h1312_1110;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (upd_a) seen.push_back(q_a);
        end
        va = '0;
        check_eq("t3_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5 && i < seen.size(); i++) check_eq("t3_seq", 32'(seen[i]), 32'(t3_exp[i]));

        // Zero hold: requesters 0 and 3 alternate every cycle
        rst = 1'b1; cycle(); rst = 1'b0;
        vb = 4'b1001; db = 32'h3300_0000 | 32'h0000_0030;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("t4_grant", 32'(ready_b), (i % 2 == 0) ? 32'b0001 : 32'b1000);
            cycle();
            check_eq("t4_upd", 32'(upd_b), 32'h1);
            check_eq("t4_busy", 32'(busy_b), 32'h0);
            check_eq("t4_q", 32'(q_b), (i % 2 == 0) ? 32'h30 : 32'h33);
        end
        vb = '0;

        // Reset during the first hold cycle
        cycle();
        va = 4'b0010; da = 32'h0000_5A00;
        cycle();
        va = '0;
        check_eq("t5_q_written", 32'(q_a), 32'h5A);
        rst = 1'b1; cycle(); rst = 1'b0;
        check_eq("t5_q_reset", 32'(q_a), 32'h00);
        check_eq("t5_busy", 32'(busy_a), 32'h0);
        va = 4'b0010; #1;
        check_eq("t5_regrant", 32'(ready_a), 32'b0010);
        cycle();
        va = '0;
        cycle(); cycle();

`ifdef REG8_ARB_OWNER_EN
        va = 4'b1000; da = 32'h3C00_0000;
        cycle();
        va = '0;
        check_eq("t6_own3", 32'(own_a), 32'd3);
        check_eq("t6_q3", 32'(q_a), 32'h3C);
        cycle(); cycle();
        va = 4'b0010; da = 32'h0000_7E00;
        cycle();
        va = '0;
        check_eq("t6_own1", 32'(own_a), 32'd1);
        check_eq("t6_q1", 32'(q_a), 32'h7E);
        rst = 1'b1; cycle(); rst = 1'b0;
        check_eq("t6_own_rst", 32'(own_a), 32'd0);
`endif

        // Random traffic on both instances, occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            va = N'($urandom); vb = N'($urandom);
            da = $urandom; db = $urandom;
            cycle();
        end
        rst = 1'b0; va = '0; vb = '0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
